// File: rtl/cpu_sequencer_if.sv
// Control bundle between the instruction sequencer and the datapath/memory side.
// The master modport is the sequencer view; the slave modport is the datapath view.
interface cpu_sequencer_if;
    localparam int unsigned OP_W  = 5;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned ST_W  = 3;

    logic              run;
    logic [OP_W-1:0]   opcode;
    logic              dec_regwrite;
    logic              dec_memwrite;
    logic              dec_nz;
    logic              flag_z;
    logic              flag_n;
    logic              mem_ready;

    logic              mem_rd;
    logic              mem_wr;
    logic              mem_sel;
    logic              ir_we;
    logic              rf_we;
    logic              nz_we;
    logic              pc_we;
    logic [1:0]        pc_sel;
    logic              illegal;
    logic [CNT_W-1:0]  instret;
    logic [ST_W-1:0]   state;

    modport master (
        input  run, opcode, dec_regwrite, dec_memwrite, dec_nz, flag_z, flag_n, mem_ready,
        output mem_rd, mem_wr, mem_sel, ir_we, rf_we, nz_we, pc_we, pc_sel, illegal,
               instret, state
    );

    modport slave (
        output run, opcode, dec_regwrite, dec_memwrite, dec_nz, flag_z, flag_n, mem_ready,
        input  mem_rd, mem_wr, mem_sel, ir_we, rf_we, nz_we, pc_we, pc_sel, illegal,
               instret, state
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes,
// branch target selection, illegal-opcode trap pulse and retired-instruction counter.
module cpu_sequencer (
    input  logic            clk,
    input  logic            reset_n,
    cpu_sequencer_if.master bus
);
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] PC_BRANCH = 2'b00;
    localparam logic [1:0] PC_REG    = 2'b01;
    localparam logic [1:0] PC_NEXT   = 2'b10;

    localparam logic [4:0] OP_LD = 5'b00100;
    localparam logic [4:0] OP_ST = 5'b00101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   instret_q;

    logic               is_ld;
    logic               is_st;
    logic               legal;
    logic               taken;
    logic [1:0]         br_sel;

    logic               mem_rd;
    logic               mem_wr;
    logic               mem_sel;
    logic               ir_we;
    logic               rf_we;
    logic               nz_we;
    logic               pc_we;
    logic [1:0]         pc_sel;
    logic               illegal;

    assign is_ld = (bus.opcode == OP_LD);
    assign is_st = (bus.opcode == OP_ST);

    // Opcode legality table
    always_comb begin
        legal = 1'b0;
        case (bus.opcode)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110,
            5'b01000, 5'b01001, 5'b01010, 5'b01100,
            5'b11000, 5'b11001, 5'b11010, 5'b11100: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
    end

    // Branch resolution: [1:0]=00 unconditional (incl. call), 01 on Z, 10 on N
    always_comb begin
        taken = 1'b0;
        if (legal && (bus.opcode[4:3] == 2'b11 || bus.opcode[4:3] == 2'b01)) begin
            case (bus.opcode[1:0])
                2'b00:   taken = 1'b1;
                2'b01:   taken = bus.flag_z;
                2'b10:   taken = bus.flag_n;
                default: taken = 1'b0;
            endcase
        end
        br_sel = PC_NEXT;
        if (taken) begin
            br_sel = bus.opcode[4] ? PC_BRANCH : PC_REG;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and strobes; strobes decode straight from the state register so
    // an asynchronous reset clears them without waiting for a clock.
    always_comb begin
        state_d = state_q;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        mem_sel = 1'b0;
        ir_we   = 1'b0;
        rf_we   = 1'b0;
        nz_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = PC_NEXT;
        illegal = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = (is_ld || is_st) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_sel = 1'b1;
                mem_rd  = is_ld;
                mem_wr  = is_st && bus.dec_memwrite;
                if (bus.mem_ready) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_we   = 1'b1;
                rf_we   = legal && bus.dec_regwrite;
                nz_we   = legal && bus.dec_nz;
                pc_sel  = br_sel;
                illegal = !legal;
                state_d = bus.run ? S_FETCH : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Retired-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_q <= '0;
        end else if (state_q == S_WB) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign bus.mem_rd  = mem_rd;
    assign bus.mem_wr  = mem_wr;
    assign bus.mem_sel = mem_sel;
    assign bus.ir_we   = ir_we;
    assign bus.rf_we   = rf_we;
    assign bus.nz_we   = nz_we;
    assign bus.pc_we   = pc_we;
    assign bus.pc_sel  = pc_sel;
    assign bus.illegal = illegal;
    assign bus.instret = instret_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-instruction WB expectations are queued
// at issue and popped when the sequencer reaches WB.
module tb_cpu_sequencer;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;

    typedef struct packed {
        logic [4:0]  op;
        logic [1:0]  pc_sel;
        logic        rf_we;
        logic        nz_we;
        logic        illegal;
        logic [15:0] instret;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] model_instret;

    // {mem_rd, mem_wr, mem_sel, ir_we, rf_we, nz_we, pc_we, illegal, pc_sel}
    function automatic logic [9:0] obs();
        return {bus.mem_rd, bus.mem_wr, bus.mem_sel, bus.ir_we, bus.rf_we,
                bus.nz_we, bus.pc_we, bus.illegal, bus.pc_sel};
    endfunction

    // Reference WB behaviour built from the opcode list and branch table
    function automatic exp_t model(input logic [4:0] op, input logic rw, input logic nz,
                                   input logic fz, input logic fn);
        logic [4:0] legal_ops [19] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
                                       5'h10, 5'h11, 5'h12, 5'h13, 5'h16,
                                       5'h08, 5'h09, 5'h0A, 5'h0C,
                                       5'h18, 5'h19, 5'h1A, 5'h1C};
        exp_t e;
        logic lg;
        logic tk;
        lg = 1'b0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) lg = 1'b1;
        case (op)
            5'b11000, 5'b11100, 5'b01000, 5'b01100: tk = 1'b1;
            5'b11001, 5'b01001:                     tk = fz;
            5'b11010, 5'b01010:                     tk = fn;
            default:                                tk = 1'b0;
        endcase
        e.op      = op;
        e.pc_sel  = !tk ? 2'b10 : (op[4:3] == 2'b11 ? 2'b00 : 2'b01);
        e.rf_we   = lg & rw;
        e.nz_we   = lg & nz;
        e.illegal = !lg;
        e.instret = '0;
        return e;
    endfunction

    task automatic exec_instr(input logic [4:0] op, input logic rw, input logic nz,
                              input logic fz, input logic fn, input int mem_wait,
                              input bit drop_run);
        exp_t e;
        exp_t g;
        int   cyc;
        int   mem_cyc;
        bit   done;
        bit   is_ld;
        bit   is_st;
        int   want_lat;
        e = model(op, rw, nz, fz, fn);
        e.instret = model_instret + 16'd1;
        sb.push_back(e);
        is_ld = (op == 5'b00100);
        is_st = (op == 5'b00101);
        want_lat = (is_ld || is_st) ? 5 + mem_wait : 4;
        bus.opcode = op; bus.dec_regwrite = rw; bus.dec_nz = nz;
        bus.dec_memwrite = is_st; bus.flag_z = fz; bus.flag_n = fn;
        bus.mem_ready = 1'b1; bus.run = 1'b1;
        cyc = 0;
        while (bus.state != ST_FETCH && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        cyc = 0; mem_cyc = 0; done = 1'b0;
        while (!done && cyc < 64) begin
            cyc++;
            n_cmp++;
            case (bus.state)
                ST_FETCH: if (obs() !== 10'b1001_0000_10) begin
                    n_bad++;
                    $display("FAIL fetch_strobes op=%b: got %b want %b", op, obs(), 10'b1001_0000_10);
                end
                ST_DECODE, ST_EXEC: begin
                    if (obs() !== 10'b0000_0000_10) begin
                        n_bad++;
                        $display("FAIL dec_exec_strobes op=%b st=%0d: got %b want %b", op, bus.state, obs(), 10'b0000_0000_10);
                    end
                    if (bus.state == ST_EXEC && drop_run) bus.run = 1'b0;
                end
                ST_MEM: begin
                    if (obs() !== {is_ld, is_st, 1'b1, 5'b0, 2'b10}) begin
                        n_bad++;
                        $display("FAIL mem_strobes op=%b: got %b want %b", op, obs(), {is_ld, is_st, 1'b1, 5'b0, 2'b10});
                    end
                    bus.mem_ready = (mem_cyc >= mem_wait);
                    mem_cyc++;
                end
                ST_WB: begin
                    done = 1'b1;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL wb_scoreboard_empty op=%b", op);
                    end else begin
                        g = sb.pop_front();
                        if (obs() !== {4'b0, g.rf_we, g.nz_we, 1'b1, g.illegal, g.pc_sel}) begin
                            n_bad++;
                            $display("FAIL wb_strobes op=%b: got %b want %b", g.op, obs(),
                                     {4'b0, g.rf_we, g.nz_we, 1'b1, g.illegal, g.pc_sel});
                        end
                    end
                end
                default: begin
                    done = 1'b1;
                    n_bad++;
                    $display("FAIL state_walk op=%b: got state %0d want 1..5", op, bus.state);
                end
            endcase
            @(negedge clk);
        end
        n_cmp++;
        if (cyc !== want_lat) begin
            n_bad++;
            $display("FAIL latency op=%b: got %0d want %0d", op, cyc, want_lat);
        end
        n_cmp++;
        if (bus.instret !== e.instret) begin
            n_bad++;
            $display("FAIL instret op=%b: got %h want %h", op, bus.instret, e.instret);
        end
        n_cmp++;
        if (bus.state !== (drop_run ? ST_IDLE : ST_FETCH)) begin
            n_bad++;
            $display("FAIL wb_exit op=%b: got %0d want %0d", op, bus.state, drop_run ? ST_IDLE : ST_FETCH);
        end
        model_instret = e.instret;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.run = 1'b1; bus.opcode = 5'b00001; bus.dec_regwrite = 1'b1; bus.dec_memwrite = 1'b1;
        bus.dec_nz = 1'b1; bus.flag_z = 1'b1; bus.flag_n = 1'b1; bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.state, bus.instret, obs()} !== {ST_IDLE, 16'h0000, 10'b0000_0000_10}) begin
            n_bad++;
            $display("FAIL reset_values: got st=%0d cnt=%h io=%b want st=0 cnt=0000 io=0000000010",
                     bus.state, bus.instret, obs());
        end
        bus.run = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.state, obs()} !== {ST_IDLE, 10'b0000_0000_10}) begin
            n_bad++;
            $display("FAIL idle_parked: got st=%0d io=%b want st=0 io=0000000010", bus.state, obs());
        end
        model_instret = 16'h0000;
    endtask

    task automatic test_alu();
        exec_instr(5'b00001, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        exec_instr(5'b10010, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        exec_instr(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_mem();
        exec_instr(5'b00101, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        exec_instr(5'b00100, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        exec_instr(5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        exec_instr(5'b00101, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_branch();
        exec_instr(5'b11001, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        exec_instr(5'b11001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        exec_instr(5'b01010, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        exec_instr(5'b01010, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        exec_instr(5'b11000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        exec_instr(5'b01100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        exec_instr(5'b11100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        exec_instr(5'b01001, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        exec_instr(5'b11010, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_illegal();
        exec_instr(5'b11111, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        exec_instr(5'b00001, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        exec_instr(5'b00110, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        exec_instr(5'b11011, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        exec_instr(5'b10111, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            exec_instr(5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    task automatic test_run_drop();
        exec_instr(5'b00011, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.state, obs(), bus.instret} !== {ST_IDLE, 10'b0000_0000_10, model_instret}) begin
            n_bad++;
            $display("FAIL run_drop_idle: got st=%0d io=%b cnt=%h want st=0 io=0000000010 cnt=%h",
                     bus.state, obs(), bus.instret, model_instret);
        end
        exec_instr(5'b00101, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.instret_q = 16'hFFFF;
        #1;
        release dut.instret_q;
        model_instret = 16'hFFFF;
        exec_instr(5'b00001, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        exec_instr(5'b00010, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_mem();
        int cyc;
        bus.opcode = 5'b00101; bus.dec_memwrite = 1'b1; bus.dec_regwrite = 1'b0;
        bus.dec_nz = 1'b0; bus.mem_ready = 1'b1; bus.run = 1'b1;
        cyc = 0;
        while (bus.state != ST_MEM && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.state, obs()} !== {ST_MEM, 10'b0110_0000_10}) begin
            n_bad++;
            $display("FAIL pre_reset_mem: got st=%0d io=%b want st=4 io=0110000010", bus.state, obs());
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.state, bus.instret, obs()} !== {ST_IDLE, 16'h0000, 10'b0000_0000_10}) begin
            n_bad++;
            $display("FAIL async_reset_mem: got st=%0d cnt=%h io=%b want st=0 cnt=0000 io=0000000010",
                     bus.state, bus.instret, obs());
        end
        model_instret = 16'h0000;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.state !== ST_FETCH) begin
            n_bad++;
            $display("FAIL reset_release_fetch: got %0d want %0d", bus.state, ST_FETCH);
        end
        exec_instr(5'b00001, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_run_drop();
        test_wrap();
        test_reset_mid_mem();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
